// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC and the IF/ID register, applies stall/redirect
// from ID, and freezes fetch on HALT while counting the pipeline drain up to Finish.
module if_stage #(
  parameter int DRAIN_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_init,
  input  logic [31:0] i_data,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] i_addr,
  output logic [31:0] PC,
  output logic [31:0] IF_ins,
  output logic [31:0] ID_ins,
  output logic [31:0] ID_pc4,
  output logic        halted,
  output logic        Finish,
  output logic [1:0]  dbg_state
);

  localparam int CW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DRAIN_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [31:0]   pc_q, pc_d;
  logic [31:0]   ins_q, ins_d;
  logic [31:0]   pc4_q, pc4_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   pc_plus4;
  logic          is_halt;

  assign pc_plus4 = pc_q + 32'd4;
  assign is_halt  = (i_data[31:26] == 6'h3f);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ins_d   = ins_q;
    pc4_d   = pc4_q;
    cnt_d   = cnt_q;
    if (state_q != ST_RUN) begin
      // Draining: PC is frozen; each advance pushes a bubble into ID.
      if (!stall) begin
        ins_d = 32'd0;
        pc4_d = 32'd0;
        if (cnt_q == CNT_LAST) begin
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
    end else if (stall) begin
      // Hold everything; a coincident redirect is re-asserted by ID later.
    end else if (redirect) begin
      pc_d  = redirect_pc;
      ins_d = 32'd0;
      pc4_d = 32'd0;
    end else begin
      ins_d = i_data;
      pc4_d = pc_plus4;
      if (is_halt) begin
        state_d = ST_DRAIN;
        cnt_d   = '0;
      end else begin
        pc_d = pc_plus4;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RUN;
      pc_q    <= pc_init;
      ins_q   <= 32'd0;
      pc4_q   <= 32'd0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ins_q   <= ins_d;
      pc4_q   <= pc4_d;
      cnt_q   <= cnt_d;
    end
  end

  assign i_addr    = {pc_q[31:2], 2'b00};
  assign PC        = pc_q;
  assign IF_ins    = i_data;
  assign ID_ins    = ins_q;
  assign ID_pc4    = pc4_q;
  assign halted    = (state_q != ST_RUN);
  assign Finish    = (state_q == ST_DONE);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: directed scenarios plus randomized traffic against a
// cycle-level behavioural model of fetch, stall, redirect, halt and drain.
module tb_if_stage;
  localparam int DRAIN = 4;

  logic        clk = 1'b0;
  logic        rst, stall, redirect;
  logic [31:0] pc_init, redirect_pc, i_data;
  logic [31:0] i_addr, pc, if_ins, id_ins, id_pc4;
  logic        halted, finish;
  logic [1:0]  dbg_state;

  logic [31:0] mem [0:255];

  int n_checks = 0;
  int n_pass   = 0;

  // model state
  logic [31:0] m_pc, m_ins, m_pc4;
  logic        m_halted;
  int          m_adv;

  always #5 clk = ~clk;

  assign i_data = mem[i_addr[9:2]];

  if_stage #(.DRAIN_CYCLES(DRAIN)) dut (
    .clk(clk), .rst(rst), .pc_init(pc_init), .i_data(i_data), .stall(stall),
    .redirect(redirect), .redirect_pc(redirect_pc), .i_addr(i_addr), .PC(pc),
    .IF_ins(if_ins), .ID_ins(id_ins), .ID_pc4(id_pc4), .halted(halted),
    .Finish(finish), .dbg_state(dbg_state)
  );

  function automatic logic m_finish();
    return m_halted && (m_adv >= DRAIN);
  endfunction

  // Drive one cycle, advance the model from its pre-edge state, sample after the edge.
  task automatic step(input logic r, input logic s, input logic d,
                      input logic [31:0] rpc, input logic [31:0] pinit);
    logic [31:0] w;
    rst = r; stall = s; redirect = d; redirect_pc = rpc; pc_init = pinit;
    w = mem[m_pc[9:2]];
    if (r) begin
      m_pc = pinit; m_ins = 0; m_pc4 = 0; m_halted = 0; m_adv = 0;
    end else if (m_halted) begin
      if (!s) begin m_ins = 0; m_pc4 = 0; m_adv++; end
    end else if (s) begin
      m_adv = m_adv;
    end else if (d) begin
      m_pc = rpc; m_ins = 0; m_pc4 = 0;
    end else begin
      m_ins = w; m_pc4 = m_pc + 32'd4;
      if (w[31:26] == 6'h3f) begin m_halted = 1; m_adv = 0; end
      else m_pc = m_pc + 32'd4;
    end
    @(posedge clk); #1;
    rst = 0; stall = 0; redirect = 0;
  endtask

  task automatic fill_mem(input int halt_pct);
    logic [31:0] w;
    for (int i = 0; i < 256; i++) begin
      w = $urandom;
      if (w[31:26] == 6'h3f) w[31] = 1'b0;
      if ($urandom_range(99) < halt_pct) w = 32'hFC00_0000 | ($urandom & 32'h03FF_FFFF);
      mem[i] = w;
    end
  endtask

  task automatic test_reset();
    fill_mem(0);
    mem[4] = 32'h2001_0005; mem[5] = 32'h2002_0007; mem[6] = 32'h0022_1820;
    step(1, 0, 0, 0, 32'h10);
    n_checks++; if (pc !== 32'h10) $display("FAIL reset_pc got %h exp %h", pc, 32'h10); else n_pass++;
    n_checks++; if (id_ins !== 32'h0) $display("FAIL reset_id_ins got %h exp 0", id_ins); else n_pass++;
    n_checks++; if (id_pc4 !== 32'h0) $display("FAIL reset_id_pc4 got %h exp 0", id_pc4); else n_pass++;
    n_checks++; if ({halted, finish} !== 2'b00) $display("FAIL reset_flags got %b exp 00", {halted, finish}); else n_pass++;
    n_checks++; if (i_addr !== 32'h10) $display("FAIL reset_i_addr got %h exp 10", i_addr); else n_pass++;
  endtask

  task automatic test_sequence();
    logic [31:0] exp_pc [3];
    logic [31:0] exp_ins [3];
    exp_pc  = '{32'h14, 32'h18, 32'h1C};
    exp_ins = '{32'h2001_0005, 32'h2002_0007, 32'h0022_1820};
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 0, 32'h10);
      n_checks++; if (pc !== exp_pc[i]) $display("FAIL seq_pc[%0d] got %h exp %h", i, pc, exp_pc[i]); else n_pass++;
      n_checks++; if (id_ins !== exp_ins[i]) $display("FAIL seq_id_ins[%0d] got %h exp %h", i, id_ins, exp_ins[i]); else n_pass++;
      n_checks++; if (id_pc4 !== exp_pc[i]) $display("FAIL seq_id_pc4[%0d] got %h exp %h", i, id_pc4, exp_pc[i]); else n_pass++;
    end
  endtask

  task automatic test_stall();
    step(1, 0, 0, 0, 32'h10);
    step(0, 0, 0, 0, 32'h10);
    for (int i = 0; i < 2; i++) begin
      step(0, 1, 0, 0, 32'h10);
      n_checks++; if (pc !== 32'h14) $display("FAIL stall_pc[%0d] got %h exp 14", i, pc); else n_pass++;
      n_checks++; if (id_ins !== mem[4]) $display("FAIL stall_id_ins[%0d] got %h exp %h", i, id_ins, mem[4]); else n_pass++;
      n_checks++; if (if_ins !== mem[5]) $display("FAIL stall_if_ins[%0d] got %h exp %h", i, if_ins, mem[5]); else n_pass++;
    end
    step(0, 0, 0, 0, 32'h10);
    n_checks++; if (id_ins !== mem[5]) $display("FAIL stall_release got %h exp %h", id_ins, mem[5]); else n_pass++;
    n_checks++; if (pc !== 32'h18) $display("FAIL stall_release_pc got %h exp 18", pc); else n_pass++;
  endtask

  task automatic test_redirect();
    step(1, 0, 0, 0, 32'h20);
    step(0, 0, 1, 32'h40, 32'h20);
    n_checks++; if (pc !== 32'h40) $display("FAIL redir_pc got %h exp 40", pc); else n_pass++;
    n_checks++; if ({id_ins, id_pc4} !== 64'h0) $display("FAIL redir_flush got %h/%h exp 0/0", id_ins, id_pc4); else n_pass++;
    step(0, 0, 0, 0, 32'h20);
    n_checks++; if (id_ins !== mem[16]) $display("FAIL redir_target got %h exp %h", id_ins, mem[16]); else n_pass++;
    n_checks++; if (id_pc4 !== 32'h44) $display("FAIL redir_pc4 got %h exp 44", id_pc4); else n_pass++;
    step(1, 0, 0, 0, 32'h20);
    step(0, 1, 1, 32'h40, 32'h20);
    n_checks++; if (pc !== 32'h20) $display("FAIL redir_stalled_pc got %h exp 20", pc); else n_pass++;
  endtask

  task automatic test_halt(input int stall_at);
    int edges;
    mem[12] = 32'hFFFF_FFFF;
    step(1, 0, 0, 0, 32'h2C);
    step(0, 0, 0, 0, 32'h2C);
    step(0, 0, 0, 0, 32'h2C);
    n_checks++; if (id_ins !== 32'hFFFF_FFFF) $display("FAIL halt_latch_ins got %h exp ffffffff", id_ins); else n_pass++;
    n_checks++; if ({halted, finish} !== 2'b10) $display("FAIL halt_latch_flags got %b exp 10", {halted, finish}); else n_pass++;
    n_checks++; if (pc !== 32'h30) $display("FAIL halt_latch_pc got %h exp 30", pc); else n_pass++;
    edges = 0;
    for (int i = 1; i <= 8 && !finish; i++) begin
      step(0, (i == stall_at), $urandom_range(1), $urandom, 32'h2C);
      edges = i;
      n_checks++; if (pc !== 32'h30) $display("FAIL halt_pc_frozen[%0d] got %h exp 30", i, pc); else n_pass++;
      n_checks++; if ((i != stall_at) && id_ins !== 32'h0) $display("FAIL halt_bubble[%0d] got %h exp 0", i, id_ins); else n_pass++;
    end
    n_checks++;
    if (edges !== ((stall_at > 0) ? 5 : 4))
      $display("FAIL halt_finish_edges got %0d exp %0d", edges, (stall_at > 0) ? 5 : 4);
    else n_pass++;
    step(0, 0, 0, 0, 32'h2C);
    n_checks++; if (finish !== 1'b1) $display("FAIL finish_sticky got %b exp 1", finish); else n_pass++;
  endtask

  task automatic test_reset_in_done();
    step(1, 0, 0, 0, 32'h100);
    n_checks++; if ({halted, finish} !== 2'b00) $display("FAIL done_reset_flags got %b exp 00", {halted, finish}); else n_pass++;
    n_checks++; if (pc !== 32'h100) $display("FAIL done_reset_pc got %h exp 100", pc); else n_pass++;
    n_checks++; if (id_ins !== 32'h0) $display("FAIL done_reset_ins got %h exp 0", id_ins); else n_pass++;
  endtask

  task automatic test_halt_redirect();
    step(1, 0, 0, 0, 32'h30);
    step(0, 0, 1, 32'h80, 32'h30);
    n_checks++; if (pc !== 32'h80) $display("FAIL hr_pc got %h exp 80", pc); else n_pass++;
    n_checks++; if (halted !== 1'b0) $display("FAIL hr_halted got %b exp 0", halted); else n_pass++;
    n_checks++; if (id_ins !== 32'h0) $display("FAIL hr_ins got %h exp 0", id_ins); else n_pass++;
  endtask

  task automatic test_wrap();
    mem[255] = 32'h0000_0020;
    step(1, 0, 0, 0, 32'hFFFF_FFFC);
    step(0, 0, 0, 0, 32'hFFFF_FFFC);
    n_checks++; if (pc !== 32'h0) $display("FAIL wrap_pc got %h exp 0", pc); else n_pass++;
    n_checks++; if (id_pc4 !== 32'h0) $display("FAIL wrap_pc4 got %h exp 0", id_pc4); else n_pass++;
    step(1, 0, 0, 0, 32'h13);
    n_checks++; if (i_addr !== 32'h10) $display("FAIL mask_i_addr got %h exp 10", i_addr); else n_pass++;
    step(0, 0, 0, 0, 32'h13);
    n_checks++; if (pc !== 32'h17) $display("FAIL mask_pc_carry got %h exp 17", pc); else n_pass++;
  endtask

  task automatic test_random();
    logic [31:0] exp_addr;
    fill_mem(4);
    step(1, 0, 0, 0, $urandom);
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(99) < 2), ($urandom_range(99) < 25), ($urandom_range(99) < 15),
           $urandom, $urandom);
      exp_addr = {m_pc[31:2], 2'b00};
      n_checks++; if (pc !== m_pc) $display("FAIL rnd_pc[%0d] got %h exp %h", i, pc, m_pc); else n_pass++;
      n_checks++; if (i_addr !== exp_addr) $display("FAIL rnd_i_addr[%0d] got %h exp %h", i, i_addr, exp_addr); else n_pass++;
      n_checks++; if (if_ins !== mem[m_pc[9:2]]) $display("FAIL rnd_if_ins[%0d] got %h exp %h", i, if_ins, mem[m_pc[9:2]]); else n_pass++;
      n_checks++; if (id_ins !== m_ins) $display("FAIL rnd_id_ins[%0d] got %h exp %h", i, id_ins, m_ins); else n_pass++;
      n_checks++; if (!m_halted && id_pc4 !== m_pc4) $display("FAIL rnd_id_pc4[%0d] got %h exp %h", i, id_pc4, m_pc4); else n_pass++;
      n_checks++; if (halted !== m_halted) $display("FAIL rnd_halted[%0d] got %b exp %b", i, halted, m_halted); else n_pass++;
      n_checks++; if (finish !== m_finish()) $display("FAIL rnd_finish[%0d] got %b exp %b", i, finish, m_finish()); else n_pass++;
    end
  endtask

  initial begin
    rst = 1; stall = 0; redirect = 0; redirect_pc = 0; pc_init = 0;
    m_pc = 0; m_ins = 0; m_pc4 = 0; m_halted = 0; m_adv = 0;
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    test_reset();
    test_sequence();
    test_stall();
    test_redirect();
    test_halt(0);
    test_reset_in_done();
    test_halt(2);
    test_halt_redirect();
    test_wrap();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/if_stage.md
# if_stage

Instruction-fetch stage of the five-stage MIPS-subset pipeline. It owns the PC register and the IF/ID pipeline register, and it drives the instruction-memory address. It applies stall, flush and branch/jump redirects coming from ID, and detects HALT. After HALT it freezes fetch, counts the pipeline drain and raises `Finish` for the bench. It sits directly upstream of the decode/hazard logic that consumes `ID_ins`.

## Interface
- `DRAIN_CYCLES`, default 4: number of non-stalled advances after HALT is latched into IF/ID before `Finish` rises (ID→EX→DM→WB, then done).
- `clk` input 1: single clock; all state updates on posedge.
- `rst` input 1: synchronous, active-high reset. Sampled on posedge `clk`.
- `pc_init` input 32: start PC, loaded at reset (from the instruction image header).
- `i_data` input 32: instruction word at `i_addr`, valid combinationally in the same cycle.
- `stall` input 1: hold PC and IF/ID this cycle (load-use / branch-operand hazard).
- `redirect` input 1: taken branch/jump resolved in ID; flush IF.
- `redirect_pc` input 32: target PC, valid while `redirect`=1.
- `i_addr` output 32: `{PC[31:2],2'b00}`.
- `PC` output 32: current fetch PC.
- `IF_ins` output 32: word being fetched this cycle; equals `i_data` (snapshot display).
- `ID_ins` output 32: IF/ID instruction register.
- `ID_pc4` output 32: PC+4 of `ID_ins`, used for branch/JAL targets.
- `halted` output 1: HALT latched; fetch frozen.
- `Finish` output 1: drain complete. Sticky until reset.

## Operation
- Reset values: `PC`=`pc_init`; `ID_ins`=0 (NOP); `ID_pc4`=0; `halted`=0; drain counter=0; `Finish`=0.
- Per-cycle priority, evaluated when not in reset:
  - **halted**: `PC` holds. Each non-stalled cycle loads `ID_ins`←0 and increments the counter. `stall` and `redirect` do not affect `PC`. When the counter reaches `DRAIN_CYCLES-1` and the cycle is not stalled, `Finish`←1 and the counter saturates.
  - **stall=1**: `PC`, `ID_ins` and `ID_pc4` hold. `redirect` in the same cycle is ignored; ID re-asserts it after the stall clears.
  - **redirect=1**: `PC`←`redirect_pc`; `ID_ins`←0 (the fetched word is flushed); `ID_pc4`←0. HALT detection is suppressed for the flushed word.
  - **normal**: `PC`←`PC`+4 (mod 2^32, wraps 0xFFFFFFFC→0); `ID_ins`←`i_data`; `ID_pc4`←`PC`+4.
- HALT detection applies only in the normal case and only when `halted`=0. If `i_data[31:26]`=6'h3f, it is latched into `ID_ins` as usual, `halted`←1, and `PC` holds at the HALT address instead of incrementing.
- States:
  - RUN (`halted`=0) → DRAIN on HALT latch.
  - DRAIN (`halted`=1, `Finish`=0) → DONE after `DRAIN_CYCLES` non-stalled advances, counting the HALT-latch cycle as advance 0.
  - DONE (`Finish`=1) → RUN only on `rst`.
- `IF_ins` is always the raw `i_data`, including during stall, redirect and halted cycles.
- `PC[1:0]` is carried unchanged in `PC` but masked on `i_addr`.

## Timing
- Fetch latency: the word at `PC` appears on `ID_ins` one posedge later.
- Redirect penalty: one bubble. The target word is in IF in cycle N+1 and in ID in cycle N+2.
- A stall of k cycles delays `ID_ins` by exactly k cycles. No instruction is lost or duplicated.
- `Finish` rises `DRAIN_CYCLES` advances after the posedge that latched HALT, not counting stalled cycles.
- Reset asserted mid-operation (including DRAIN or DONE) returns everything to the reset values on that posedge. `pc_init` is sampled at that edge.

## Test plan
- Reset with `pc_init`=0x00000010, then 3 free cycles with memory returning 0x20010005, 0x20020007, 0x00221820 → `PC` steps 0x10→0x14→0x18→0x1C; `ID_ins` sequence 0x20010005, 0x20020007, 0x00221820; `ID_pc4`=0x14, 0x18, 0x1C.
- At `PC`=0x14, assert `stall` for 2 cycles → `PC` stays 0x14 and `ID_ins` holds its prior value for both cycles; on release `ID_ins`=word@0x14.
- At `PC`=0x20, pulse `redirect` with `redirect_pc`=0x40 → next cycle `PC`=0x40 and `ID_ins`=0; following cycle `ID_ins`=word@0x40. Repeat with `stall`=1 in the same cycle → redirect ignored, `PC` stays 0x20.
- HALT 0xFFFFFFFF fetched at 0x30 → `ID_ins`=0xFFFFFFFF, `halted`=1, `PC` frozen at 0x30, `ID_ins`=0 thereafter. `Finish`=1 exactly 4 posedges after the latch with no stalls, or 5 with one stall inserted.
- HALT fetched in the same cycle as `redirect` to 0x80 → no halt; `PC`=0x80, `halted`=0.
- `pc_init`=0xFFFFFFFC → next `PC`=0x00000000. Assert `rst` while in DONE → `Finish`=0, `halted`=0, `PC`=`pc_init`, `ID_ins`=0.
